// File: rtl/osd_pkg.sv
// Shared OSD definitions: position width, 2-bit OSD colour codes, colour-to-RGB
// constants and the packed video word carried through the delay line.
package osd_pkg;

    localparam int unsigned POS_W = 11;

    // OSD colour codes as produced by the OSD generator
    localparam logic [1:0] BG_BLACK  = 2'd0;
    localparam logic [1:0] BG_BLUE   = 2'd1;
    localparam logic [1:0] BG_YELLOW = 2'd2;
    localparam logic [1:0] BG_WHITE  = 2'd3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t RGB_BLUE   = '{r: 8'h00, g: 8'h00, b: 8'hC0};
    localparam rgb_t RGB_YELLOW = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t RGB_WHITE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

    // One pixel slot: syncs, data enable and colour
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        rgb_t rgb;
    } vid_t;

    localparam int unsigned VID_W = $bits(vid_t);

    function automatic rgb_t color_to_rgb(input logic [1:0] code);
        rgb_t c;
        c = RGB_BLACK;
        unique case (code)
            BG_BLACK:  c = RGB_BLACK;
            BG_BLUE:   c = RGB_BLUE;
            BG_YELLOW: c = RGB_YELLOW;
            BG_WHITE:  c = RGB_WHITE;
        endcase
        return c;
    endfunction

    // Only the dark background colours may be blended with video
    function automatic logic is_blendable(input logic [1:0] code);
        return (code == BG_BLACK) || (code == BG_BLUE);
    endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-length shift register delaying a video word by Depth clock cycles.
// Ports: vclk/rst_n clock and async active-low reset, data_i word in,
// data_o word out Depth cycles later (all stages clear to 0 on reset).
module pixel_delay_line #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 27
) (
    input  logic             vclk,
    input  logic             rst_n,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
        stage_d[0] = data_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/osd_overlay_mixer.sv
// OSD overlay mixer. Generates active-area xpos/ypos for an external OSD
// generator, delays the incoming video by OSD_LATENCY cycles so it lines up
// with the generator's osd_enable/osd_color answer, then mixes and registers.
// Ports:
//   vclk, rst_n                 pixel clock, async active-low reset
//   R_i/G_i/B_i, hsync_i,
//   vsync_i, de_i               input video
//   osd_blend_i                 quasi-static 50 % blend of black/blue OSD
//   xpos, ypos                  registered position to the OSD generator
//   osd_enable, osd_color       OSD generator result, OSD_LATENCY after sample
//   R_o/G_o/B_o, hsync_o,
//   vsync_o, de_o               mixed video, OSD_LATENCY+1 after input
module osd_overlay_mixer
    import osd_pkg::*;
#(
    parameter int unsigned OSD_LATENCY = 8,
    parameter logic        VSYNC_POL   = 1'b0
) (
    input  logic             vclk,
    input  logic             rst_n,
    input  logic [7:0]       R_i,
    input  logic [7:0]       G_i,
    input  logic [7:0]       B_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic             osd_blend_i,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    input  logic             osd_enable,
    input  logic [1:0]       osd_color,
    output logic [7:0]       R_o,
    output logic [7:0]       G_o,
    output logic [7:0]       B_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o
);

    localparam logic [POS_W-1:0] POS_MAX = '1;
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    // ---------------------------------------------------------------
    // Position counters
    // ---------------------------------------------------------------
    logic             de_prev_q, vsync_prev_q;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic             de_fall, vsync_start;

    assign de_fall     = de_prev_q && !de_i;
    assign vsync_start = (vsync_i == VSYNC_POL) && (vsync_prev_q != VSYNC_POL);

    always_comb begin
        xpos_d = xpos_q;
        if (de_i) begin
            if (!de_prev_q) begin
                xpos_d = '0;
            end else if (xpos_q != POS_MAX) begin
                xpos_d = xpos_q + POS_ONE;
            end
        end

        // Frame start wins over a coincident end of line
        ypos_d = ypos_q;
        if (vsync_start) begin
            ypos_d = '0;
        end else if (de_fall && (ypos_q != POS_MAX)) begin
            ypos_d = ypos_q + POS_ONE;
        end
    end

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_q    <= 1'b0;
            vsync_prev_q <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
        end else begin
            de_prev_q    <= de_i;
            vsync_prev_q <= vsync_i;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;

    // ---------------------------------------------------------------
    // Video delay to meet the OSD generator's answer
    // ---------------------------------------------------------------
    vid_t             vid_in, vid_dly;
    logic [VID_W-1:0] dly_bits;

    assign vid_in = '{hsync: hsync_i, vsync: vsync_i, de: de_i,
                      rgb: '{r: R_i, g: G_i, b: B_i}};

    pixel_delay_line #(
        .Depth (OSD_LATENCY),
        .Width (VID_W)
    ) u_delay (
        .vclk   (vclk),
        .rst_n  (rst_n),
        .data_i (vid_in),
        .data_o (dly_bits)
    );

    assign vid_dly = dly_bits;

    // ---------------------------------------------------------------
    // Mixer and output register
    // ---------------------------------------------------------------
    rgb_t osd_rgb, mix_rgb;
    vid_t out_q, out_d;

    always_comb begin
        osd_rgb = color_to_rgb(osd_color);
        mix_rgb = vid_dly.rgb;
        // OSD only ever replaces active video; blanking passes untouched
        if (osd_enable && vid_dly.de) begin
            if (osd_blend_i && is_blendable(osd_color)) begin
                mix_rgb.r = (vid_dly.rgb.r >> 1) + (osd_rgb.r >> 1);
                mix_rgb.g = (vid_dly.rgb.g >> 1) + (osd_rgb.g >> 1);
                mix_rgb.b = (vid_dly.rgb.b >> 1) + (osd_rgb.b >> 1);
            end else begin
                mix_rgb = osd_rgb;
            end
        end
        out_d     = vid_dly;
        out_d.rgb = mix_rgb;
    end

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign R_o     = out_q.rgb.r;
    assign G_o     = out_q.rgb.g;
    assign B_o     = out_q.rgb.b;
    assign hsync_o = out_q.hsync;
    assign vsync_o = out_q.vsync;
    assign de_o    = out_q.de;

endmodule

// File: tb/tb_osd_overlay_mixer.sv
// Self-checking bench for osd_overlay_mixer: table vectors for the mixer,
// directed sequences for position counters, latency and reset, and random
// traffic checked every cycle against a queue-based reference model.
module tb_osd_overlay_mixer;

    localparam int unsigned L         = 8;
    localparam logic        VSYNC_POL = 1'b0;
    localparam logic        VS_IDLE   = ~VSYNC_POL;

    logic        vclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        hs_in = 1'b0, vs_in = VS_IDLE, de_in = 1'b0;
    logic        blend = 1'b0;
    logic        osd_en = 1'b0;
    logic [1:0]  osd_col = 2'd0;
    logic [10:0] xpos, ypos;
    logic [7:0]  r_out, g_out, b_out;
    logic        hs_out, vs_out, de_out;

    osd_overlay_mixer #(
        .OSD_LATENCY (L),
        .VSYNC_POL   (VSYNC_POL)
    ) dut (
        .vclk        (vclk),
        .rst_n       (rst_n),
        .R_i         (r_in),
        .G_i         (g_in),
        .B_i         (b_in),
        .hsync_i     (hs_in),
        .vsync_i     (vs_in),
        .de_i        (de_in),
        .osd_blend_i (blend),
        .xpos        (xpos),
        .ypos        (ypos),
        .osd_enable  (osd_en),
        .osd_color   (osd_col),
        .R_o         (r_out),
        .G_o         (g_out),
        .B_o         (b_out),
        .hsync_o     (hs_out),
        .vsync_o     (vs_out),
        .de_o        (de_out)
    );

    always #5 vclk = ~vclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } samp_t;

    samp_t pq[$];
    int    run_len, falls, exp_x;
    logic  prev_de, prev_vs;

    function automatic logic [23:0] ref_mix(input logic [23:0] pix, input logic de,
                                            input logic en, input logic [1:0] col,
                                            input logic bl);
        int v[3];
        int o[3];
        int res[3];
        if (!en || !de) return pix;
        v[0] = int'(pix[23:16]);
        v[1] = int'(pix[15:8]);
        v[2] = int'(pix[7:0]);
        case (col)
            2'd0:    o = '{0, 0, 0};
            2'd1:    o = '{0, 0, 192};
            2'd2:    o = '{255, 255, 0};
            default: o = '{255, 255, 255};
        endcase
        for (int c = 0; c < 3; c++) begin
            res[c] = (bl && col < 2'd2) ? (v[c] / 2 + o[c] / 2) : o[c];
        end
        return {8'(res[0]), 8'(res[1]), 8'(res[2])};
    endfunction

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < int'(L); i++) pq.push_back('0);
        run_len = 0;
        falls   = 0;
        exp_x   = 0;
        prev_de = 1'b0;
        prev_vs = 1'b0;
    endtask

    // One clock: model consumes what the DUT samples, then outputs are compared
    task automatic tick();
        samp_t       s, d;
        logic [23:0] exp_rgb;
        @(posedge vclk);
        s = {hs_in, vs_in, de_in, r_in, g_in, b_in};
        if (de_in) begin
            run_len = prev_de ? run_len + 1 : 1;
            exp_x   = (run_len - 1 > 2047) ? 2047 : run_len - 1;
        end
        if (vs_in == VSYNC_POL && prev_vs != VSYNC_POL) falls = 0;
        else if (prev_de && !de_in) falls++;
        prev_de = de_in;
        prev_vs = vs_in;
        pq.push_back(s);
        d = pq.pop_front();
        exp_rgb = ref_mix(d.rgb, d.de, osd_en, osd_col, blend);
        #1;
        check("xpos", 32'(xpos), exp_x);
        check("ypos", 32'(ypos), (falls > 2047) ? 2047 : falls);
        check("rgb", 32'({r_out, g_out, b_out}), 32'(exp_rgb));
        check("sync", 32'({hs_out, vs_out, de_out}), 32'({d.hs, d.vs, d.de}));
    endtask

    task automatic drive(input logic [23:0] pix, input logic de, input logic vs,
                         input logic en, input logic [1:0] col);
        {r_in, g_in, b_in} = pix;
        de_in   = de;
        vs_in   = vs;
        osd_en  = en;
        osd_col = col;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_xpos", 32'(xpos), 0);
        check("rst_ypos", 32'(ypos), 0);
        check("rst_rgb", 32'({r_out, g_out, b_out}), 0);
        check("rst_sync", 32'({hs_out, vs_out, de_out}), 0);
        @(posedge vclk);
        @(posedge vclk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [23:0] pix;
        logic        de;
        logic        en;
        logic [1:0]  col;
        logic        bl;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{24'h0A141E, 1'b1, 1'b1, 2'd3, 1'b0, 24'hFFFFFF};
        vecs[1]  = '{24'h0A141E, 1'b1, 1'b0, 2'd3, 1'b0, 24'h0A141E};
        vecs[2]  = '{24'h808080, 1'b1, 1'b1, 2'd1, 1'b1, 24'h4040A0};
        vecs[3]  = '{24'h808080, 1'b1, 1'b1, 2'd2, 1'b1, 24'hFFFF00};
        vecs[4]  = '{24'h808080, 1'b1, 1'b1, 2'd0, 1'b1, 24'h404040};
        vecs[5]  = '{24'hFFFFFF, 1'b1, 1'b1, 2'd1, 1'b1, 24'h7F7FDF};
        vecs[6]  = '{24'h123456, 1'b1, 1'b1, 2'd0, 1'b0, 24'h000000};
        vecs[7]  = '{24'h123456, 1'b1, 1'b1, 2'd1, 1'b0, 24'h0000C0};
        vecs[8]  = '{24'h123456, 1'b1, 1'b1, 2'd3, 1'b1, 24'hFFFFFF};
        vecs[9]  = '{24'hFF0180, 1'b1, 1'b0, 2'd1, 1'b1, 24'hFF0180};
        vecs[10] = '{24'h556677, 1'b0, 1'b1, 2'd3, 1'b0, 24'h556677};
        vecs[11] = '{24'h0A141E, 1'b1, 1'b1, 2'd1, 1'b1, 24'h050A6F};

        #2;
        do_reset();

        // Mixer table: hold each vector long enough to fill the pipeline
        for (int i = 0; i < 12; i++) begin
            blend = vecs[i].bl;
            drive(vecs[i].pix, vecs[i].de, VS_IDLE, vecs[i].en, vecs[i].col);
            repeat (L + 2) tick();
            check($sformatf("vec%0d", i), 32'({r_out, g_out, b_out}), 32'(vecs[i].exp));
        end
        blend = 1'b0;
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        repeat (L + 2) tick();

        // 720-pixel line right after a frame start
        drive('0, 1'b0, VSYNC_POL, 1'b0, 2'd0);
        tick();
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        tick();
        for (int i = 0; i < 720; i++) begin
            drive(24'(i), 1'b1, VS_IDLE, 1'b0, 2'd0);
            tick();
            check("line_x", 32'(xpos), i);
            check("line_y", 32'(ypos), 0);
        end
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        tick();
        check("line_yinc", 32'(ypos), 1);
        check("line_xhold", 32'(xpos), 719);
        repeat (L + 2) tick();

        // Exact latency: pixel at one slot, OSD answer exactly L slots later
        for (int pass = 0; pass < 2; pass++) begin
            drive(24'h0A141E, 1'b1, VS_IDLE, 1'b0, 2'd0);
            tick();
            for (int i = 1; i <= int'(L); i++) begin
                drive('0, 1'b0, VS_IDLE, (i == int'(L)) && (pass == 0), 2'd3);
                tick();
            end
            check(pass == 0 ? "lat_osd" : "lat_video", 32'({r_out, g_out, b_out}),
                  pass == 0 ? 32'hFFFFFF : 32'h0A141E);
            check("lat_de", 32'(de_out), 1);
            drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
            tick();
            check("lat_after", 32'(de_out), 0);
        end

        // Frame start coincident with end of line
        for (int ln = 0; ln < 2; ln++) begin
            drive(24'h111111, 1'b1, VS_IDLE, 1'b0, 2'd0);
            repeat (3) tick();
            drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
            tick();
        end
        drive(24'h222222, 1'b1, VS_IDLE, 1'b0, 2'd0);
        repeat (3) tick();
        drive('0, 1'b0, VSYNC_POL, 1'b0, 2'd0);
        tick();
        check("vs_fall_y", 32'(ypos), 0);
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        tick();

        // Saturation: long line, then many lines
        drive(24'h333333, 1'b1, VS_IDLE, 1'b0, 2'd0);
        repeat (4000) tick();
        check("xsat", 32'(xpos), 2047);
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        tick();
        for (int ln = 0; ln < 3000; ln++) begin
            drive(24'h444444, 1'b1, VS_IDLE, 1'b0, 2'd0);
            tick();
            drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
            tick();
        end
        check("ysat", 32'(ypos), 2047);

        // Reset in the middle of a line
        drive(24'h555555, 1'b1, VS_IDLE, 1'b0, 2'd0);
        repeat (20) tick();
        do_reset();
        check("rel_de0", 32'(de_out), 0);
        for (int i = 1; i <= int'(L); i++) begin
            tick();
            check("rel_de_low", 32'(de_out), 0);
        end
        tick();
        check("rel_de_high", 32'(de_out), 1);
        check("rel_y", 32'(ypos), 0);
        drive('0, 1'b0, VS_IDLE, 1'b0, 2'd0);
        tick();
        check("rel_yinc", 32'(ypos), 1);

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) blend = 1'($urandom_range(0, 1));
            hs_in = 1'($urandom_range(0, 1));
            drive(24'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 40) == 0) ? VSYNC_POL : VS_IDLE,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
        end
        hs_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
